// File: rtl/tbl_rd_engine_pkg.sv
// Shared response-record layout for the table read engine and the downstream match logic.
// A response packs as {data, tag, err}, with err in bit 0.
package tbl_rd_engine_pkg;

    localparam int unsigned ADDR_BITS_DEF = 5;
    localparam int unsigned DATA_BITS_DEF = 32;
    localparam int unsigned TAG_BITS_DEF  = 4;
    localparam int unsigned ERR_BITS      = 1;
    localparam int unsigned RSP_W_DEF     = DATA_BITS_DEF + TAG_BITS_DEF + ERR_BITS;

    typedef struct packed {
        logic [DATA_BITS_DEF-1:0] data;
        logic [TAG_BITS_DEF-1:0]  tag;
        logic                     err;
    } rsp_t;

    function automatic int unsigned rsp_width(input int unsigned data_bits,
                                              input int unsigned tag_bits);
        return data_bits + tag_bits + ERR_BITS;
    endfunction

endpackage

// File: rtl/tbl_rd_engine_fifo.sv
// Synchronous first-word-fall-through response FIFO with an occupancy count.
// The read side shows the head entry whenever valid_o is high; otherwise rdata_o is zero.
module rd_rsp_fifo
    import tbl_rd_engine_pkg::*;
#(
    parameter int unsigned WIDTH = RSP_W_DEF,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full, empty, do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop_i & ~empty;
    assign do_push = push_i & (~full | do_pop);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: storage is deliberately not reset; pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = empty ? '0 : mem_q[rd_ptr_q];
    assign valid_o = ~empty;
    assign count_o = count_q;

    overflow_a: assert property (@(posedge clk) disable iff (rst) !(push_i && full && !pop_i));

endmodule

// File: rtl/tbl_rd_engine.sv
// Valid/ready read front-end for a registered-read table RAM; results return in request
// order through a credit-managed FWFT FIFO, so downstream backpressure never drops one.
module tbl_rd_engine
    import tbl_rd_engine_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = ADDR_BITS_DEF,
    parameter int unsigned DATA_BITS   = DATA_BITS_DEF,
    parameter int unsigned TAG_BITS    = TAG_BITS_DEF,
    parameter int unsigned NUM_ENTRIES = 32,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [TAG_BITS-1:0]  req_tag,
    output logic                 ram_en,
    output logic [ADDR_BITS-1:0] ram_addr,
    input  logic [DATA_BITS-1:0] ram_dout,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_BITS-1:0] rsp_data,
    output logic [TAG_BITS-1:0]  rsp_tag,
    output logic                 rsp_err,
    output logic [31:0]          req_cnt
);

    localparam int unsigned RSP_W = rsp_width(DATA_BITS, TAG_BITS);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic                pipe_valid_q;
    logic [TAG_BITS-1:0] pipe_tag_q;
    logic                pipe_err_q;
    logic [31:0]         req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W:0]      credits_used;
    logic                accept, in_range;
    logic [RSP_W-1:0]    push_data, head_data;

    // Credits count queued entries plus the one in the pipeline slot, so a push can never overflow.
    assign credits_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, pipe_valid_q};
    assign req_ready    = credits_used < (CNT_W + 1)'(FIFO_DEPTH);
    assign accept       = req_valid & req_ready;
    assign in_range     = {1'b0, req_addr} < (ADDR_BITS + 1)'(NUM_ENTRIES);

    assign ram_en   = accept & in_range & ~rst;
    assign ram_addr = req_addr;

    assign req_cnt_d = req_cnt_q + {31'b0, accept};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid_q <= 1'b0;
            pipe_tag_q   <= '0;
            pipe_err_q   <= 1'b0;
            req_cnt_q    <= '0;
        end else begin
            pipe_valid_q <= accept;
            pipe_tag_q   <= req_tag;
            pipe_err_q   <= ~in_range;
            req_cnt_q    <= req_cnt_d;
        end
    end

    // Error slots carry zero data; the RAM output is stale in those cycles.
    assign push_data = {(pipe_err_q ? {DATA_BITS{1'b0}} : ram_dout), pipe_tag_q, pipe_err_q};

    rd_rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pipe_valid_q),
        .wdata_i (push_data),
        .pop_i   (rsp_ready),
        .rdata_o (head_data),
        .valid_o (rsp_valid),
        .count_o (fifo_count)
    );

    assign rsp_data = head_data[RSP_W-1 -: DATA_BITS];
    assign rsp_tag  = head_data[TAG_BITS:1];
    assign rsp_err  = head_data[0];
    assign req_cnt  = req_cnt_q;

endmodule

// File: doc/tbl_rd_engine.md
# tbl_rd_engine

Request/response read front-end for the dual-port table RAM used by the Menshen lookup stages. It accepts lookup reads on a valid/ready request channel, drives the RAM read port (address, enable), and captures the RAM data one cycle later. Each result, with its request tag, is returned through an internal response FIFO, so downstream backpressure never drops a result. It sits between the key extractor / match logic and each table RAM instance; the table write port stays with the control-path writer.

## Interface
- ADDR_BITS, 5, RAM address width
- DATA_BITS, 32, RAM word width
- TAG_BITS, 4, opaque request tag width, echoed in the response
- NUM_ENTRIES, 32, number of valid entries (≤ 2^ADDR_BITS); addresses ≥ NUM_ENTRIES are errors
- FIFO_DEPTH, 4, response FIFO depth (≥ 3 for full rate; 2 legal, reduced rate)

- clk  in  1  single clock for all logic
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_addr  in  ADDR_BITS  table index
- req_tag  in  TAG_BITS  request tag
- ram_en  out  1  RAM read enable
- ram_addr  out  ADDR_BITS  RAM read address
- ram_dout  in  DATA_BITS  RAM read data, valid exactly one cycle after ram_en
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_data  out  DATA_BITS  read data (all zeros when rsp_err)
- rsp_tag  out  TAG_BITS  echoed tag
- rsp_err  out  1  address out of range
- req_cnt  out  32  accepted-request counter, wraps at 2^32

## Operation
- Accept = req_valid & req_ready. On accept with req_addr < NUM_ENTRIES: ram_en=1 and ram_addr=req_addr in the same cycle. Both are combinational from the request.
- On accept with req_addr ≥ NUM_ENTRIES: ram_en=0. An error response {data=0, tag, err=1} follows the same one-cycle pipeline slot, so responses stay in request order.
- A pipeline register holds {valid, tag, err} for one cycle. In the next cycle it pushes {ram_dout or 0, tag, err} into the FIFO.
- Credit rule: req_ready = (fifo_count + inflight) < FIFO_DEPTH, where inflight is the pipeline-register valid bit. req_ready depends only on registered state, never on rsp_ready or req_valid.
- The FIFO is first-word-fall-through: rsp_* show the head entry whenever rsp_valid=1. Push and pop in the same cycle are legal. When full, the count is unchanged by a simultaneous push and pop.
- Overflow cannot happen by construction. A push while full is an assertion failure in simulation.
- req_cnt increments by 1 on every accept, including error requests. It wraps from 0xFFFFFFFF to 0.

## Timing
- Latency: accept in cycle N gives rsp_valid in cycle N+2 at the earliest (pipeline register, then FIFO).
- Throughput with FIFO_DEPTH ≥ 3 and rsp_ready held at 1: one response per cycle. With FIFO_DEPTH=2: 2 responses per 3 cycles.
- Reset (asynchronous, active-high) clears FIFO pointers and count, the inflight bit, and req_cnt.
  - Reset values: req_ready=1, rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_err=0, ram_en=0, req_cnt=0.
  - Reset mid-operation discards all in-flight and queued responses. No response is emitted for them after reset release.
- While rst=1, ram_en=0 regardless of req_valid.
- The RAM must present data with registered-read timing (one-cycle latency). The block does not check for read-during-write on the same address; the write-side owner handles that hazard.

## Structure
- Shared header/package: response record field widths (TAG_BITS, DATA_BITS, err bit) and the packed response width DATA_BITS+TAG_BITS+1, shared with downstream match logic.
- One sub-module: rd_rsp_fifo. It is a synchronous FWFT FIFO parameterized by WIDTH and DEPTH, exposes count, and has the same asynchronous active-high reset.
- Top level: request accept, range check, pipeline register, credit logic, counter.

## Test plan
- Single read: preload RAM[3]=0xDEADBEEF; request addr=3, tag=5 in cycle 0. Expect ram_en=1 and ram_addr=3 in cycle 0; rsp_valid in cycle 2 with data=0xDEADBEEF, tag=5, err=0; req_cnt=1.
- Back-to-back: 16 requests on consecutive cycles (addr=i, tag=i mod 16) with rsp_ready=1 and FIFO_DEPTH=4. Expect req_ready to stay 1 throughout and 16 in-order responses on cycles 2..17.
- Backpressure: rsp_ready=0 with continuous requests. Expect exactly 4 accepts, then req_ready=0. Raise rsp_ready: expect 4 responses in order and no lost or duplicated tag.
- Out of range: NUM_ENTRIES=20, request addr=25, tag=2. Expect ram_en=0 and a response with data=0, err=1, tag=2. Interleave with valid reads and expect ordering preserved.
- Reset mid-flight: 3 responses queued plus 1 in flight; assert rst asynchronously mid-cycle. Expect rsp_valid=0 and req_ready=1 immediately and req_cnt=0. After release, expect no stale responses and a fresh read to return correctly.
- Counter wrap: force req_cnt to 0xFFFFFFFE, then issue 3 accepts. Expect the values 0xFFFFFFFF, 0, 1.
